// File: rtl/fifo_lvl.sv
// fifo_lvl: single-clock FIFO of any depth (not limited to powers of two).
// It provides an occupancy count, registered almost-full and almost-empty
// watermarks, and a synchronous flush. The head word q is show-ahead.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   flush         discards the contents; overflow/underflow are kept
//   d, wr         write data and write request
//   rd            read request, which pops the word on q
//   q             head of FIFO, combinational from memory, valid when !empty
//   full, empty, almost_full, almost_empty, count   registered status
//   overflow, underflow   sticky error flags
//
// Optional feature: define FIFO_LVL_ERR_FLAGS_EN to build the sticky error
// registers. Without it, overflow and underflow are tied to 0.
module fifo_lvl #(
  parameter  int unsigned WIDTH    = 16,
  parameter  int unsigned DEPTH    = 8,
  parameter  int unsigned AF_LEVEL = 6,
  parameter  int unsigned AE_LEVEL = 1,
  localparam int unsigned CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             wr,
  input  logic             rd,
  output logic [WIDTH-1:0] q,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] ri_q, ri_d;
  logic [PW-1:0] wi_q, wi_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          afull_q, afull_d;
  logic          aempty_q, aempty_d;
  logic          rd_ok, wr_ok, mem_we;

  // Pointer advance with an explicit wrap, so any depth works.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Accept logic, next pointers and count. All flags are derived from the next count.
  always_comb begin
    rd_ok    = rd & ~empty_q;
    // A full FIFO still accepts a write when a read frees a slot in the same cycle.
    wr_ok    = wr & (~full_q | rd_ok);
    ri_d     = ri_q;
    wi_d     = wi_q;
    count_d  = count_q;
    mem_we   = 1'b0;
    if (flush) begin
      ri_d    = '0;
      wi_d    = '0;
      count_d = '0;
    end else begin
      if (rd_ok) ri_d = ptr_inc(ri_q);
      if (wr_ok) wi_d = ptr_inc(wi_q);
      mem_we  = wr_ok;
      count_d = count_q + CW'(wr_ok) - CW'(rd_ok);
    end
    full_d   = (count_d == CW'(DEPTH));
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= CW'(AF_LEVEL));
    aempty_d = (count_d <= CW'(AE_LEVEL));
  end

  // Status and pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ri_q     <= '0;
      wi_q     <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      ri_q     <= ri_d;
      wi_q     <= wi_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

  // Storage array. It is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[wi_q] <= d;
  end

  assign q            = mem[ri_q];
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;

`ifdef FIFO_LVL_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky error capture. A flush cycle is not a write or read attempt.
  always_comb begin
    overflow_d  = overflow_q  | (wr & ~wr_ok & ~flush);
    underflow_d = underflow_q | (rd & empty_q & ~flush);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule
